polyphase_tx_filter: RTL and testbench

POLYPHASE_TX_FILTER -- requirements
Module: polyphase_tx_filter

---
 rtl/polyphase_tx_filter.sv | 157 +++++++++++++++
 tb/tb_polyphase_tx_filter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_tx_filter.sv
// Polyphase pulse-shaping TX filter: N_CH binary channels, OVER_SAMP phases, N_BAUDS taps.
// Define PTF_COEF_WR_EN for a writable coefficient bank; otherwise the default table is fixed.
module polyphase_tx_filter #(
   parameter int NB_COEFF  = 10,
   parameter int NBF_COEFF = 8,
   parameter int OVER_SAMP = 8,
   parameter int N_BAUDS   = 7,
   parameter int N_CH      = 2,
   parameter int NB_OUTPUT = 13
) (
   input  logic                                   clk,
   input  logic                                   i_rst,
   input  logic                                   i_enable,
   input  logic                                   i_valid,
   input  logic [N_CH-1:0]                        i_sym,
   output logic                                   o_ready,
   input  logic                                   i_coef_we,
   input  logic [$clog2(OVER_SAMP*N_BAUDS)-1:0]   i_coef_addr,
   input  logic [NB_COEFF-1:0]                    i_coef_data,
   output logic [N_CH*NB_OUTPUT-1:0]              o_data,
   output logic                                   o_valid,
   output logic [$clog2(OVER_SAMP)-1:0]           o_phase
);

   localparam int NCOEF = OVER_SAMP * N_BAUDS;
   localparam int NA    = $clog2(NCOEF);
   localparam int NP    = $clog2(OVER_SAMP);
   localparam int NS    = NB_COEFF + $clog2(N_BAUDS) + 1;
   localparam int NW    = ((NS > NB_OUTPUT) ? NS : NB_OUTPUT) + 1;
   localparam logic signed [NW-1:0] SAT_HI = NW'((2 ** (NB_OUTPUT - 1)) - 1);
   localparam logic signed [NW-1:0] SAT_LO = NW'(-(2 ** (NB_OUTPUT - 1)));

   // Raised cosine, rolloff 0.5, centred on the table, values in 1/256 units.
   function automatic logic signed [NB_COEFF-1:0] f_rc(input int n);
      int m;
      int v;
      m = (n < NCOEF / 2) ? (NCOEF / 2 - n) : (n - NCOEF / 2);
      case (m)
         0:                  v = 256;
         1:                  v = 249;
         2:                  v = 227;
         3:                  v = 194;
         4:                  v = 154;
         5:                  v = 110;
         6:                  v = 67;
         7:                  v = 30;
         9:                  v = -20;
         10, 12:             v = -31;
         11:                 v = -34;
         13:                 v = -23;
         14:                 v = -15;
         15:                 v = -6;
         17, 20:             v = 4;
         18, 19:             v = 6;
         21:                 v = 3;
         22, 26, 27, 28:     v = 1;
         default:            v = 0;
      endcase
      return NB_COEFF'((v * (2 ** NBF_COEFF)) / 256);
   endfunction

   logic signed [NB_COEFF-1:0] w_coef [NCOEF];

`ifdef PTF_COEF_WR_EN
   logic signed [NB_COEFF-1:0] r_coef [NCOEF];

   always_ff @(posedge clk) begin
      if (i_rst) begin
         for (int i = 0; i < NCOEF; i++) r_coef[i] <= f_rc(i);
      end else if (i_coef_we && ({1'b0, i_coef_addr} < (NA + 1)'(NCOEF))) begin
         r_coef[i_coef_addr] <= i_coef_data;
      end
   end

   assign w_coef = r_coef;
`else
   logic w_unused;

   for (genvar gi = 0; gi < NCOEF; gi++) begin : g_def
      assign w_coef[gi] = f_rc(gi);
   end

   assign w_unused = ^{i_coef_we, i_coef_addr, i_coef_data};
`endif

   logic [NP-1:0]              r_phase;
   logic [N_BAUDS-1:0]         r_pres [N_CH];
   logic [N_BAUDS-1:0]         r_bit  [N_CH];
   logic [N_CH*NB_OUTPUT-1:0]  r_data;
   logic [NP-1:0]              r_oph;
   logic                       r_valid;
   logic                       w_last;
   logic                       w_shift;
   logic [N_CH*NB_OUTPUT-1:0]  w_sat;
   logic signed [NW-1:0]       w_acc  [N_CH];
   logic signed [NW-1:0]       w_term;
   logic [NA-1:0]              w_idx;

   assign w_last  = (r_phase == NP'(OVER_SAMP - 1));
   assign w_shift = i_enable && w_last;
   assign o_ready = w_last;

   always_comb begin
      w_sat  = '0;
      w_term = '0;
      w_idx  = '0;
      for (int c = 0; c < N_CH; c++) begin
         w_acc[c] = '0;
         for (int k = 0; k < N_BAUDS; k++) begin
            w_idx  = NA'(k * OVER_SAMP) + NA'(r_phase);
            w_term = NW'(w_coef[w_idx]);
            if (r_pres[c][k]) begin
               w_acc[c] = r_bit[c][k] ? (w_acc[c] - w_term) : (w_acc[c] + w_term);
            end
         end
         if (w_acc[c] > SAT_HI) begin
            w_sat[c*NB_OUTPUT +: NB_OUTPUT] = SAT_HI[NB_OUTPUT-1:0];
         end else if (w_acc[c] < SAT_LO) begin
            w_sat[c*NB_OUTPUT +: NB_OUTPUT] = SAT_LO[NB_OUTPUT-1:0];
         end else begin
            w_sat[c*NB_OUTPUT +: NB_OUTPUT] = w_acc[c][NB_OUTPUT-1:0];
         end
      end
   end

   // Sum uses the pre-shift register, so the new symbol enters at phase 0.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_phase <= '0;
         r_data  <= '0;
         r_oph   <= '0;
         r_valid <= 1'b0;
         for (int c = 0; c < N_CH; c++) begin
            r_pres[c] <= '0;
            r_bit[c]  <= '0;
         end
      end else begin
         r_valid <= i_enable;
         if (i_enable) begin
            r_phase <= r_phase + 1'b1;
            r_data  <= w_sat;
            r_oph   <= r_phase;
         end
         if (w_shift) begin
            for (int c = 0; c < N_CH; c++) begin
               r_pres[c] <= {r_pres[c][N_BAUDS-2:0], i_valid};
               r_bit[c]  <= {r_bit[c][N_BAUDS-2:0], i_sym[c] & i_valid};
            end
         end
      end
   end

   assign o_data  = r_data;
   assign o_phase = r_oph;
   assign o_valid = r_valid;

endmodule

// File: tb/tb_polyphase_tx_filter.sv
// Scoreboard bench for polyphase_tx_filter: a 13-bit and a narrow-output instance share stimulus.
// Building with PTF_COEF_WR_EN adds the coefficient-write scenarios.
module tb_polyphase_tx_filter;

   localparam int OS  = 8;
   localparam int NBD = 7;
   localparam int NC  = OS * NBD;
   localparam int NBO = 13;
`ifdef PTF_COEF_WR_EN
   localparam int NBS = 11;
`else
   localparam int NBS = 8;
`endif

   typedef struct {
      int ph;
      int a0;
      int a1;
      int b0;
      int b1;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             i_rst       = 1'b1;
   logic             i_enable    = 1'b0;
   logic             i_valid     = 1'b0;
   logic             i_coef_we   = 1'b0;
   logic [1:0]       i_sym       = '0;
   logic [5:0]       i_coef_addr = '0;
   logic [9:0]       i_coef_data = '0;
   logic             rdy_a, vld_a, rdy_b, vld_b;
   logic [2*NBO-1:0] dat_a;
   logic [2*NBS-1:0] dat_b;
   logic [2:0]       ph_a, ph_b;

   polyphase_tx_filter u_dut (
      .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_valid(i_valid),
      .i_sym(i_sym), .o_ready(rdy_a), .i_coef_we(i_coef_we),
      .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
      .o_data(dat_a), .o_valid(vld_a), .o_phase(ph_a)
   );

   polyphase_tx_filter #(.NB_OUTPUT(NBS)) u_sat (
      .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_valid(i_valid),
      .i_sym(i_sym), .o_ready(rdy_b), .i_coef_we(i_coef_we),
      .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
      .o_data(dat_b), .o_valid(vld_b), .o_phase(ph_b)
   );

   int nchk  = 0;
   int nfail = 0;

   int def_tab [NC] = '{
      1, 1, 1, 0, 0, 0, 1, 3, 4, 6, 6, 4, 0, -6, -15, -23,
      -31, -34, -31, -20, 0, 30, 67, 110, 154, 194, 227, 249,
      256,
      249, 227, 194, 154, 110, 67, 30, 0, -20, -31, -34, -31,
      -23, -15, -6, 0, 4, 6, 6, 4, 3, 1, 0, 0, 0, 1, 1
   };

   int             m_coef [NC];
   bit [NBD-1:0]   m_pres [2];
   bit [NBD-1:0]   m_bit  [2];
   int             m_phase;
   exp_t           sb [$];
   exp_t           last;

   function automatic int sat(input int v, input int w);
      int hi = (1 << (w - 1)) - 1;
      int lo = -(1 << (w - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   function automatic int msum(input int c, input int p);
      int s = 0;
      for (int k = 0; k < NBD; k++) begin
         if (m_pres[c][k]) s += m_bit[c][k] ? -m_coef[p + OS * k] : m_coef[p + OS * k];
      end
      return s;
   endfunction

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_coef  = def_tab;
      for (int c = 0; c < 2; c++) begin
         m_pres[c] = '0;
         m_bit[c]  = '0;
      end
      sb.delete();
      last = '{0, 0, 0, 0, 0};
   endtask

   task automatic check_out();
      chk("o_phase_a", ph_a, last.ph);
      chk("o_phase_b", ph_b, last.ph);
      chk("ch0_a", $signed(dat_a[NBO-1:0]), last.a0);
      chk("ch1_a", $signed(dat_a[2*NBO-1:NBO]), last.a1);
      chk("ch0_b", $signed(dat_b[NBS-1:0]), last.b0);
      chk("ch1_b", $signed(dat_b[2*NBS-1:NBS]), last.b1);
   endtask

   task automatic cyc(input bit en, input bit vld, input bit [1:0] sym,
                      input bit we = 1'b0, input int addr = 0, input int dat = 0);
      exp_t e;
      i_enable    = en;
      i_valid     = vld;
      i_sym       = sym;
      i_coef_we   = we;
      i_coef_addr = 6'(addr);
      i_coef_data = 10'(dat);
      chk("o_ready", rdy_a, m_phase == OS - 1);
      if (en) begin
         e.ph = m_phase;
         e.a0 = sat(msum(0, m_phase), NBO);
         e.a1 = sat(msum(1, m_phase), NBO);
         e.b0 = sat(msum(0, m_phase), NBS);
         e.b1 = sat(msum(1, m_phase), NBS);
         sb.push_back(e);
         if (m_phase == OS - 1) begin
            for (int c = 0; c < 2; c++) begin
               m_pres[c] = {m_pres[c][NBD-2:0], vld};
               m_bit[c]  = {m_bit[c][NBD-2:0], sym[c]};
            end
         end
         m_phase = (m_phase + 1) % OS;
      end
`ifdef PTF_COEF_WR_EN
      if (we) m_coef[addr] = dat;
`endif
      @(posedge clk);
      #1;
      chk("o_valid_a", vld_a, en);
      chk("o_valid_b", vld_b, en);
      if (vld_a) begin
         if (sb.size() == 0) begin
            nchk++;
            nfail++;
            $error("FAIL scoreboard: output observed with no expected entry");
         end else begin
            last = sb.pop_front();
         end
      end
      check_out();
   endtask

   task automatic do_reset();
      i_rst       = 1'b1;
      i_enable    = 1'b1;
      i_valid     = 1'b1;
      i_sym       = 2'b11;
      i_coef_we   = 1'b1;
      i_coef_addr = 6'd28;
      i_coef_data = 10'd5;
      @(posedge clk);
      #1;
      i_rst     = 1'b0;
      i_enable  = 1'b0;
      i_valid   = 1'b0;
      i_coef_we = 1'b0;
      i_sym     = '0;
      model_reset();
      chk("rst_valid_a", vld_a, 0);
      chk("rst_valid_b", vld_b, 0);
      chk("rst_ready", rdy_a, 0);
      check_out();
   endtask

   task automatic run(input int nsym, input int mode, input int gap, input int drop);
      bit [1:0] sy;
      for (int s = 0; s < nsym; s++) begin
         case (mode)
            0:       sy = 2'b00;
            1:       sy = 2'b11;
            2:       sy = 2'($urandom_range(0, 3));
            default: sy = 2'b10;
         endcase
         for (int p = 0; p < OS; p++) begin
            repeat (gap) cyc(1'b0, 1'b0, 2'b00);
            cyc(1'b1, (m_phase == OS - 1) && (s != drop), sy);
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      repeat (3) cyc(1'b1, 1'b0, 2'b00);
      cyc(1'b1, 1'b0, 2'b00);
      cyc(1'b1, 1'b0, 2'b00);
      cyc(1'b1, 1'b1, 2'b00);
      cyc(1'b1, 1'b0, 2'b00);
      cyc(1'b0, 1'b1, 2'b00);
      cyc(1'b1, 1'b0, 2'b00);
      repeat (8) cyc(1'b1, 1'b0, 2'b00);
      run(12, 2, 0, 5);
      run(8, 0, 0, -1);
      run(8, 1, 0, -1);
      do_reset();
      run(10, 2, 0, -1);
      while (m_phase != 4) cyc(1'b1, 1'b0, 2'b00);
      do_reset();
      cyc(1'b1, 1'b0, 2'b00);
      cyc(1'b1, 1'b0, 2'b00);
      do_reset();
      run(6, 2, 2, -1);
`ifdef PTF_COEF_WR_EN
      do_reset();
      for (int i = 0; i < NC; i++) cyc(1'b0, 1'b0, 2'b00, 1'b1, i, (i == 3) ? 100 : 0);
      run(1, 3, 0, -1);
      run(1, 0, 0, 0);
      run(1, 3, 0, -1);
      repeat (3) cyc(1'b1, 1'b0, 2'b00);
      cyc(1'b1, 1'b0, 2'b00, 1'b1, 3, 50);
      while (m_phase != OS - 1) cyc(1'b1, 1'b0, 2'b00);
      cyc(1'b1, 1'b1, 2'b10);
      repeat (8) cyc(1'b1, 1'b0, 2'b00);
      for (int i = 0; i < NC; i++) cyc(1'b0, 1'b0, 2'b00, 1'b1, i, 511);
      run(8, 0, 0, -1);
      run(8, 1, 0, -1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
